regfifo_param: RTL
==================

# regfifo_param

Parametrised register-based first-word-fall-through FIFO for the packet datapath (DRA part): next generation of the fixed 528-bit × 4 register FIFO. Width and depth are parameters. Adds occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush, and overflow/underflow error pulses. Sits between packet parser stages where a shallow, flop-based, zero-read-latency buffer is needed.

## Interface
- DATA_WIDTH, 528, bits per entry (≥1)
- DEPTH, 4, number of entries (2..16)
- AFULL_TH, DEPTH-1, almost_full asserted when count ≥ AFULL_TH (1..DEPTH)
- AEMPTY_TH, 1, almost_empty asserted when count ≤ AEMPTY_TH (0..DEPTH-1)
- CNT_W (localparam), $clog2(DEPTH+1), count width

- clk  in  1  clock; all logic on rising edge
- srst  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of contents; wr_en/rd_en ignored that cycle
- wr_en  in  1  write request
- din  in  DATA_WIDTH  write data
- rd_en  in  1  read/pop request (acknowledges current dout)
- dout  out  DATA_WIDTH  head entry (entry 0), valid whenever !empty
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_TH
- almost_empty  out  1  count ≤ AEMPTY_TH
- count  out  CNT_W  number of valid entries
- overflow  out  1  one-cycle pulse: write dropped
- underflow  out  1  one-cycle pulse: read on empty

## Operation
- Storage: DEPTH registers, entry 0 is head; valid entries contiguous from 0; invalid entries hold zero.
- Registered state: entries, count, overflow, underflow. full/empty/almost_* decoded combinationally from count.
- Priority per cycle: srst > flush > wr/rd.
- srst or flush: all entries ← 0, count ← 0, overflow ← 0, underflow ← 0.
- Write only, not full: din stored at entry[count]; count+1.
- Write only, full: din dropped, contents unchanged, overflow pulse.
- Read only, not empty: entries shift down one (entry[i] ← entry[i+1]), entry[DEPTH-1] ← 0; count−1.
- Read only, empty: no change, underflow pulse.
- Write+read, 1 ≤ count ≤ DEPTH: shift down and store din at entry[count-1]; count unchanged (full FIFO accepts write when read in same cycle; no overflow).
- Write+read, empty: read ignored with underflow pulse; write accepted, din to entry 0, count ← 1.
- overflow/underflow: asserted exactly one cycle after offending edge, low otherwise (not sticky).
- count never exceeds DEPTH nor wraps below 0.

## Timing
- Reset values: dout=0, count=0, empty=1, full=0, almost_empty=1 (AEMPTY_TH ≥ 0), almost_full=0, overflow=0, underflow=0.
- Write-to-read latency: data written at edge N visible on dout after edge N when FIFO was empty (FWFT, zero extra cycles); rd_en may pop it in cycle N+1.
- Status outputs update in the same cycle count changes (after the edge); no registered look-ahead.
- dout changes only on edges where a read or a write-into-empty occurs, or on srst/flush.
- flush or srst asserted mid-stream: takes effect at that edge; concurrent wr/rd discarded, no error pulses.

## Test plan
- Reset then fill: DEPTH=4, write 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4; almost_full at count 3; full=1 after 4th; dout=0x11 throughout; no overflow.
- Overflow: full FIFO, wr_en with din=0x55, rd_en=0 -> overflow=1 for one cycle, count stays 4, contents 0x11..0x44 unchanged.
- Drain + underflow: pop 4 times -> dout 0x22,0x33,0x44,0 after each edge, empty=1; 5th rd_en -> underflow pulse, count 0.
- Simultaneous on full: full with 0x11..0x44, wr_en+rd_en din=0x55 -> dout=0x22, count 4, full stays 1, no overflow; next 3 pops yield 0x33,0x44,0x55.
- Simultaneous on empty: empty, wr_en+rd_en din=0xAA -> underflow pulse, count 1, dout=0xAA, empty=0.
- Flush/reset mid-operation: count=2, assert flush with wr_en=1 -> count 0, dout 0, no overflow/underflow; repeat with srst -> same; parametrised run DATA_WIDTH=8, DEPTH=16 random wr/rd against scoreboard model.

Source files
------------

// File: rtl/regfifo_param_if.sv
// Handshake/data bundle for regfifo_param: write side, read side and status.
interface regfifo_param_if #(
  parameter int unsigned DATA_WIDTH = 528,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_en, din, rd_en,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, din, rd_en,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/regfifo_param.sv
// Flop-based first-word-fall-through FIFO: entry 0 is the head, valid entries
// packed from 0 upward, unused entries kept at zero.
module regfifo_param #(
  parameter int unsigned DATA_WIDTH = 528,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AFULL_TH   = DEPTH - 1,
  parameter int unsigned AEMPTY_TH  = 1
) (
  input  logic            clk,
  input  logic            srst,
  regfifo_param_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT  = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] AEMPTY_CNT = CNT_W'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  full_w, empty_w;
  logic                  do_rd, do_wr;
  logic [CNT_W-1:0]      wr_idx;

  assign full_w  = (count_q == FULL_CNT);
  assign empty_w = (count_q == '0);

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    do_rd   = bus.rd_en && !empty_w;
    // A full FIFO still accepts a write when the same cycle pops a word.
    do_wr   = bus.wr_en && (!full_w || bus.rd_en);
    wr_idx  = do_rd ? (count_q - 1'b1) : count_q;

    if (bus.flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_d[i] = '0;
      count_d = '0;
    end else begin
      ovf_d = bus.wr_en && !bus.rd_en && full_w;
      unf_d = bus.rd_en && empty_w;
      if (do_rd) begin
        for (int unsigned i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
        mem_d[DEPTH-1] = '0;
      end
      // Write slot is chosen after the shift so write+read lands at count-1.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (do_wr && (wr_idx == CNT_W'(i))) mem_d[i] = bus.din;
      end
      count_d = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.dout         = mem_q[0];
  assign bus.count        = count_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= AFULL_CNT);
  assign bus.almost_empty = (count_q <= AEMPTY_CNT);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule
